// File: rtl/stochastic_number_generator.sv
// stochastic_number_generator
// Encodes a WIDTH-bit unsigned value as a unipolar stochastic bitstream of
// N = 2^WIDTH - 1 bits. Each bit compares the held value against (LFSR - 1),
// where the LFSR is maximal-length. Because (LFSR - 1) visits every value
// 0..N-1 exactly once per period, the stream carries exactly `value` ones.
module stochastic_number_generator #(
   parameter int WIDTH = 8,
   parameter int SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic             en,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

   // Feedback tap masks, bit (tap-1) set for each 1-indexed tap position.
   function automatic logic [11:0] taps_for(input int w);
      logic [11:0] mask;
      case (w)
         32'sd4:  mask = 12'b0000_0000_1100;  // 4,3
         32'sd5:  mask = 12'b0000_0001_0100;  // 5,3
         32'sd6:  mask = 12'b0000_0011_0000;  // 6,5
         32'sd7:  mask = 12'b0000_0110_0000;  // 7,6
         32'sd8:  mask = 12'b0000_1011_1000;  // 8,6,5,4
         32'sd9:  mask = 12'b0001_0001_0000;  // 9,5
         32'sd10: mask = 12'b0010_0100_0000;  // 10,7
         32'sd11: mask = 12'b0101_0000_0000;  // 11,9
         32'sd12: mask = 12'b1000_0010_1001;  // 12,6,4,1
         default: mask = 12'b0000_0000_1100;
      endcase
      return mask;
   endfunction

   localparam logic [11:0]      TAPS12     = taps_for(WIDTH);
   localparam logic [WIDTH-1:0] TAP_MASK   = TAPS12[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] SEED_TRUNC = WIDTH'(SEED);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF   = (SEED_TRUNC == {WIDTH{1'b0}}) ? ONE : SEED_TRUNC;
   // Index of the final stream bit (N-1 = 2^WIDTH - 2).
   localparam logic [WIDTH-1:0] CNT_LAST   = {{(WIDTH-1){1'b1}}, 1'b0};

   // Even parity (XOR reduction) of a WIDTH-bit vector.
   function automatic logic parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Fibonacci LFSR step, shifting toward the MSB.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], parity(v & TAP_MASK)};
   endfunction

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_value;
   logic             r_out_bit;
   logic             r_out_valid;
   logic             r_out_last;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_lfsr_next;
   logic [WIDTH-1:0] w_cnt_next;
   logic [WIDTH-1:0] w_value_next;
   logic             w_bit_next;
   logic             w_valid_next;
   logic             w_last_next;
   logic [WIDTH-1:0] w_lfsr_m1;

   assign w_lfsr_m1 = r_lfsr - ONE;

   // Next-state and next-output decode for the IDLE/RUN controller.
   always_comb begin
      w_state_next = r_state;
      w_lfsr_next  = r_lfsr;
      w_cnt_next   = r_cnt;
      w_value_next = r_value;
      w_bit_next   = r_out_bit;
      w_valid_next = 1'b0;
      w_last_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_value_next = in_value;
               w_lfsr_next  = SEED_EFF;
               w_cnt_next   = {WIDTH{1'b0}};
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (en) begin
               w_bit_next   = (w_lfsr_m1 < r_value);
               w_valid_next = 1'b1;
               w_lfsr_next  = lfsr_next(r_lfsr);
               w_cnt_next   = r_cnt + ONE;
               if (r_cnt == CNT_LAST) begin
                  w_last_next  = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_last_next  = 1'b0;
               end
            end else begin
               // Frozen: state, LFSR, count, value and out_bit all hold.
               w_valid_next = 1'b0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_lfsr      <= SEED_EFF;
         r_cnt       <= {WIDTH{1'b0}};
         r_value     <= {WIDTH{1'b0}};
         r_out_bit   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_lfsr      <= w_lfsr_next;
         r_cnt       <= w_cnt_next;
         r_value     <= w_value_next;
         r_out_bit   <= w_bit_next;
         r_out_valid <= w_valid_next;
         r_out_last  <= w_last_next;
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);
   assign out_bit   = r_out_bit;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_stochastic_number_generator.sv
// Scoreboard bench: stimulus pushes expected {last,bit} entries per stream,
// independent monitors pop and compare whenever out_valid is seen.
module tb_stochastic_number_generator;

   logic clk;
   logic rst;

   logic       in_valid4, in_ready4, en4, out_bit4, out_valid4, out_last4, busy4;
   logic [3:0] in_value4;
   logic       in_valid5, in_ready5, en5, out_bit5, out_valid5, out_last5, busy5;
   logic [4:0] in_value5;
   logic       in_valid8, in_ready8, en8, out_bit8, out_valid8, out_last8, busy8;
   logic [7:0] in_value8;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] q4[$];
   logic [1:0] q5[$];
   logic [1:0] q8[$];
   int hist_bits4[$], hist_ones4[$];
   int hist_bits5[$], hist_ones5[$];
   int hist_bits8[$], hist_ones8[$];
   int run_bits4 = 0, run_ones4 = 0;
   int run_bits5 = 0, run_ones5 = 0;
   int run_bits8 = 0, run_ones8 = 0;
   logic en_q4 = 1'b1;
   int idle_run8 = 0;
   logic after_last8 = 1'b0;
   int gap8 = -1;

   // WIDTH=4 LFSR sequence from seed 1, written out by hand.
   int seq4[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

   stochastic_number_generator #(.WIDTH(4), .SEED(1)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_value(in_value4), .en(en4), .out_bit(out_bit4),
      .out_valid(out_valid4), .out_last(out_last4), .busy(busy4));

   stochastic_number_generator #(.WIDTH(5), .SEED(0)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
      .in_value(in_value5), .en(en5), .out_bit(out_bit5),
      .out_valid(out_valid5), .out_last(out_last5), .busy(busy5));

   stochastic_number_generator #(.WIDTH(8), .SEED(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_value(in_value8), .en(en8), .out_bit(out_bit8),
      .out_valid(out_valid8), .out_last(out_last8), .busy(busy8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void check_eq(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Reference LFSR step for widths 5 and 8, taps written explicitly.
   function automatic int ref_next(input int w, input int l);
      logic [11:0] v;
      logic        fb;
      v = 12'(l);
      if (w == 5) fb = v[4] ^ v[2];
      else        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      return ((l << 1) | int'(fb)) & ((1 << w) - 1);
   endfunction

   task automatic push_stream(input int w, input int value);
      int n, l;
      logic [1:0] e;
      n = (1 << w) - 1;
      l = 1;
      for (int i = 0; i < n; i++) begin
         if (w == 4) l = seq4[i];
         e = {(i == n - 1), ((l - 1) < value)};
         if (w == 4)      q4.push_back(e);
         else if (w == 5) q5.push_back(e);
         else             q8.push_back(e);
         if (w != 4) l = ref_next(w, l);
      end
   endtask

   function automatic int hsize(input int w);
      if (w == 4)      return hist_bits4.size();
      else if (w == 5) return hist_bits5.size();
      else             return hist_bits8.size();
   endfunction

   function automatic logic rdy(input int w);
      if (w == 4)      return in_ready4;
      else if (w == 5) return in_ready5;
      else             return in_ready8;
   endfunction

   task automatic wait_hist(input int w, input int target);
      for (int k = 0; k < 2000; k++) begin
         if (hsize(w) >= target) break;
         @(negedge clk); #1;
      end
      check_eq($sformatf("stream_done_w%0d", w), int'(hsize(w) >= target), 1);
   endtask

   task automatic send(input int w, input int value);
      for (int k = 0; k < 100; k++) begin
         if (rdy(w)) break;
         @(negedge clk); #1;
      end
      check_eq($sformatf("in_ready_before_send_w%0d", w), int'(rdy(w)), 1);
      if (w == 4)      begin in_valid4 = 1'b1; in_value4 = 4'(value); end
      else if (w == 5) begin in_valid5 = 1'b1; in_value5 = 5'(value); end
      else             begin in_valid8 = 1'b1; in_value8 = 8'(value); end
      @(negedge clk); #1;
      in_valid4 = 1'b0;
      in_valid5 = 1'b0;
      in_valid8 = 1'b0;
   endtask

   task automatic check_last_stream(input int w, input int value);
      int n;
      n = (1 << w) - 1;
      if (w == 4) begin
         check_eq("bits_w4", hist_bits4[hist_bits4.size()-1], n);
         check_eq($sformatf("ones_w4_v%0d", value), hist_ones4[hist_ones4.size()-1], value);
      end else if (w == 5) begin
         check_eq("bits_w5", hist_bits5[hist_bits5.size()-1], n);
         check_eq($sformatf("ones_w5_v%0d", value), hist_ones5[hist_ones5.size()-1], value);
      end else begin
         check_eq("bits_w8", hist_bits8[hist_bits8.size()-1], n);
         check_eq($sformatf("ones_w8_v%0d", value), hist_ones8[hist_ones8.size()-1], value);
      end
   endtask

   // Record en as the DUT saw it at each rising edge.
   initial forever begin
      @(posedge clk);
      en_q4 = en4;
   end

   // Monitor for the WIDTH=4 instance.
   initial forever begin
      logic [1:0] e;
      @(negedge clk);
      if (out_valid4) begin
         check_eq("sb4_entry_available", int'(q4.size() != 0), 1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            check_eq("sb4_bit", int'(out_bit4), int'(e[0]));
            check_eq("sb4_last", int'(out_last4), int'(e[1]));
         end
         check_eq("valid_only_after_en", int'(en_q4), 1);
         run_bits4++;
         run_ones4 += int'(out_bit4);
         if (out_last4) begin
            hist_bits4.push_back(run_bits4);
            hist_ones4.push_back(run_ones4);
            run_bits4 = 0;
            run_ones4 = 0;
         end
      end
   end

   // Monitor for the WIDTH=5 instance.
   initial forever begin
      logic [1:0] e;
      @(negedge clk);
      if (out_valid5) begin
         check_eq("sb5_entry_available", int'(q5.size() != 0), 1);
         if (q5.size() != 0) begin
            e = q5.pop_front();
            check_eq("sb5_bit", int'(out_bit5), int'(e[0]));
            check_eq("sb5_last", int'(out_last5), int'(e[1]));
         end
         run_bits5++;
         run_ones5 += int'(out_bit5);
         if (out_last5) begin
            hist_bits5.push_back(run_bits5);
            hist_ones5.push_back(run_ones5);
            run_bits5 = 0;
            run_ones5 = 0;
         end
      end
   end

   // Monitor for the WIDTH=8 instance, also measuring the inter-stream gap.
   initial forever begin
      logic [1:0] e;
      @(negedge clk);
      if (out_valid8) begin
         check_eq("sb8_entry_available", int'(q8.size() != 0), 1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check_eq("sb8_bit", int'(out_bit8), int'(e[0]));
            check_eq("sb8_last", int'(out_last8), int'(e[1]));
         end
         if (after_last8) gap8 = idle_run8;
         idle_run8 = 0;
         after_last8 = out_last8;
         run_bits8++;
         run_ones8 += int'(out_bit8);
         if (out_last8) begin
            hist_bits8.push_back(run_bits8);
            hist_ones8.push_back(run_ones8);
            run_bits8 = 0;
            run_ones8 = 0;
         end
      end else begin
         idle_run8++;
      end
   end

   initial begin
      int vals5[4] = '{0, 1, 16, 31};
      rst = 1'b0;
      in_valid4 = 1'b0; in_value4 = 4'd0; en4 = 1'b1;
      in_valid5 = 1'b0; in_value5 = 5'd0; en5 = 1'b1;
      in_valid8 = 1'b0; in_value8 = 8'd0; en8 = 1'b1;

      // Reset state.
      #2;
      check_eq("rst_out_bit", int'(out_bit4), 0);
      check_eq("rst_out_valid", int'(out_valid4), 0);
      check_eq("rst_out_last", int'(out_last4), 0);
      check_eq("rst_busy", int'(busy4), 0);
      #10 rst = 1'b1;
      #1;
      check_eq("in_ready_after_rst", int'(in_ready4), 1);
      @(negedge clk); #1;

      // WIDTH=4: value 0, 15 and 5 with en held high.
      push_stream(4, 0);
      send(4, 0);
      wait_hist(4, 1);
      check_last_stream(4, 0);
      check_eq("in_ready_after_last", int'(in_ready4), 1);
      push_stream(4, 15);
      send(4, 15);
      wait_hist(4, 2);
      check_last_stream(4, 15);
      push_stream(4, 5);
      send(4, 5);
      wait_hist(4, 3);
      check_last_stream(4, 5);

      // WIDTH=4: value 9 with en toggled pseudo-randomly.
      push_stream(4, 9);
      send(4, 9);
      for (int k = 0; k < 600; k++) begin
         if (hist_bits4.size() >= 4) break;
         en4 = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
      end
      en4 = 1'b1;
      wait_hist(4, 4);
      check_last_stream(4, 9);
      @(negedge clk); #1;

      // Asynchronous reset in the middle of an all-ones stream.
      push_stream(4, 15);
      send(4, 15);
      for (int k = 0; k < 100; k++) begin
         if (run_bits4 >= 7) break;
         @(negedge clk); #1;
      end
      check_eq("abort_reached_bit7", run_bits4, 7);
      #1 rst = 1'b0;
      #1;
      check_eq("abort_out_bit", int'(out_bit4), 0);
      check_eq("abort_out_valid", int'(out_valid4), 0);
      check_eq("abort_out_last", int'(out_last4), 0);
      check_eq("abort_busy", int'(busy4), 0);
      q4.delete();
      run_bits4 = 0;
      run_ones4 = 0;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("abort_in_ready", int'(in_ready4), 1);
      check_eq("abort_no_last", hist_bits4.size(), 4);
      @(negedge clk); #1;
      push_stream(4, 5);
      send(4, 5);
      wait_hist(4, 5);
      check_last_stream(4, 5);

      // WIDTH=8: back-to-back 100 then 200, with a mid-stream value change.
      push_stream(8, 100);
      push_stream(8, 200);
      in_valid8 = 1'b1;
      in_value8 = 8'd100;
      for (int k = 0; k < 600; k++) begin
         if (run_bits8 >= 50) break;
         @(negedge clk); #1;
      end
      in_value8 = 8'd37;
      for (int k = 0; k < 600; k++) begin
         if (run_bits8 >= 100) break;
         @(negedge clk); #1;
      end
      in_value8 = 8'd200;
      wait_hist(8, 1);
      check_last_stream(8, 100);
      @(negedge clk); #1;
      check_eq("w8_second_accepted", int'(busy8), 1);
      in_valid8 = 1'b0;
      wait_hist(8, 2);
      check_last_stream(8, 200);
      check_eq("w8_idle_gap", gap8, 1);

      // WIDTH=5, SEED=0 behaves as seed 1.
      for (int i = 0; i < 4; i++) begin
         push_stream(5, vals5[i]);
         send(5, vals5[i]);
         wait_hist(5, i + 1);
         check_last_stream(5, vals5[i]);
      end

      repeat (3) @(negedge clk);
      #1;
      check_eq("q4_drained", q4.size(), 0);
      check_eq("q5_drained", q5.size(), 0);
      check_eq("q8_drained", q8.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stochastic_number_generator.md
Name: stochastic_number_generator

Overview:
Converts a WIDTH-bit unsigned binary value into a unipolar stochastic bitstream of fixed length N = 2^WIDTH - 1.
- Each output bit is the result of comparing the held value against a maximal-length LFSR sequence.
- The stream contains exactly `value` ones per period.
- Sits directly upstream of the 1-bit delay/decorrelation shift-register stage; out_bit feeds that stage's data_in.

Parameters:
WIDTH, 8, binary value width and LFSR width; supported range 4..12.
SEED, 1, LFSR start state, reloaded on every accepted value. SEED mod 2^WIDTH == 0 is replaced by 1.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  in_value is presented
in_ready  output  1  block can accept a value; high only in IDLE
in_value  input  WIDTH  unsigned value to encode
en  input  1  advance enable; when low in RUN, all state and LFSR freeze
out_bit  output  1  stochastic bit, registered
out_valid  output  1  out_bit is a new stream bit this cycle
out_last  output  1  high together with out_valid on bit N of the stream
busy  output  1  high in RUN

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE. LFSR = SEED, value_reg = 0, cnt = 0.
  - out_bit = 0, out_valid = 0, out_last = 0, busy = 0. in_ready = 1 once rst is released.
- Reset asserted mid-stream aborts the stream immediately. No out_last is produced.
- States: IDLE and RUN. in_ready = (state == IDLE); busy = (state == RUN).
- IDLE:
  - On an edge with in_valid && in_ready: value_reg <= in_value, LFSR <= SEED, cnt <= 0, state <= RUN. en is ignored for acceptance.
  - Every IDLE edge sets out_valid <= 0 and out_last <= 0.
- RUN, edge with en = 1:
  - out_bit <= ((LFSR - 1) < value_reg), compared as unsigned WIDTH-bit.
  - out_valid <= 1.
  - LFSR <= next(LFSR). cnt <= cnt + 1.
  - If cnt == N-1: out_last <= 1 and state <= IDLE. Otherwise out_last <= 0.
- RUN, edge with en = 0:
  - out_valid <= 0, out_last <= 0.
  - LFSR, cnt, value_reg and out_bit hold.
- in_valid during RUN is ignored; the value is not queued.
- LFSR is Fibonacci, shift toward the MSB: next = {LFSR[WIDTH-2:0], fb}, where fb is the XOR of the tap bits (1-indexed). Taps by WIDTH:
  - 4: 4,3
  - 5: 5,3
  - 6: 6,5
  - 7: 7,6
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
- The LFSR never reaches 0. Over a full period, LFSR-1 takes each value 0..N-1 exactly once. Therefore:
  - the count of ones equals in_value for in_value <= N;
  - in_value = 2^WIDTH-1 gives all ones;
  - in_value = 0 gives all zeros.
- Latency: acceptance edge T → first out_valid after edge T+1 (with en = 1) → last bit after edge T+N.
- Back-to-back streams: a value offered continuously is accepted on the edge after the out_last edge. This leaves exactly one out_valid = 0 cycle between streams.
- No backpressure from downstream. The shift-register stage samples every cycle, so the consumer gates on out_valid.

Test Plan:
- WIDTH=4, SEED=1, in_value=0, en=1 → 15 out_valid bits, all 0; out_last on the 15th; in_ready returns high on the next cycle.
- WIDTH=4, in_value=15 → 15 ones. in_value=5 → exactly 5 ones in 15 bits, matching the reference model bit-for-bit for LFSR sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8.
- WIDTH=8, in_value=100 then 200 with in_valid held high → 255 bits with 100 ones, exactly one idle cycle, then 255 bits with 200 ones. A new in_value presented mid-stream is ignored.
- en toggled pseudo-randomly (~50%) during a WIDTH=4, in_value=9 stream → the out_valid bit sequence equals the en=1 sequence; exactly 15 valid bits with 9 ones; no out_valid while en=0.
- rst pulsed low asynchronously (between clock edges) at bit 7 → all outputs 0 immediately, in_ready=1 after release. The next stream restarts from SEED and is complete.
- SEED=0, WIDTH=5 → behaves identically to SEED=1; 31-bit stream; ones count equals in_value for values 0, 1, 16, 31.
